lsu_rmw: RTL and testbench

//  Load/store unit sitting directly upstream of the word-only data memory (64 x 32b, combinational read, posedge write).

---
 rtl/lsu_pkg.sv | 34 +++
 rtl/lsu_align.sv | 53 +++++
 rtl/lsu_rmw.sv | 156 +++++++++++++++
 tb/tb_lsu_rmw.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - RV32I load/store funct3 encodings (F3_B .. F3_HU)
//   - RMW state encoding (ST_IDLE, ST_MERGE)
//   - access_bad(): flags illegal size codes and misaligned accesses
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_MERGE = 1'b1
    } state_t;

    // Unsigned sizes only exist for loads, so BU/HU stores count as illegal.
    function automatic logic access_bad(input logic       write,
                                        input logic [2:0] f3,
                                        input logic [1:0] off);
        logic bad;
        case (f3)
            F3_B:    bad = 1'b0;
            F3_BU:   bad = write;
            F3_H:    bad = off[0];
            F3_HU:   bad = write | off[0];
            F3_W:    bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Purely combinational lane handling for the load/store unit.
// Ports:
//   funct3     in   3   access size / signedness
//   offset     in   2   byte offset within the word (addr[1:0])
//   mem_rdata  in   32  word read from data memory
//   store_data in   16  low half of the store data (only B/H lanes are merged)
//   load_data  out  32  selected lane, sign/zero extended (0 for illegal codes)
//   merge_data out  32  mem_rdata with the store lane replaced
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] mem_rdata,
    input  logic [15:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = mem_rdata[{offset, 3'b000} +: 8];
        half_sel = offset[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    end

    always_comb begin
        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data = {24'h000000, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data = {16'h0000, half_sel};
            F3_W:    load_data = mem_rdata;
            default: load_data = 32'h0000_0000;
        endcase
    end

    // Halfword stores are already known to be halfword aligned, so offset[1]
    // alone picks the lane.
    always_comb begin
        merge_data = mem_rdata;
        case (funct3)
            F3_B: merge_data[{offset, 3'b000} +: 8] = store_data[7:0];
            F3_H: begin
                if (offset[1]) merge_data[31:16] = store_data;
                else           merge_data[15:0]  = store_data;
            end
            default: merge_data = mem_rdata;
        endcase
    end

endmodule

// File: rtl/lsu_rmw.sv
// Load/store unit in front of a word-only data memory (combinational read,
// posedge write). Loads and SW complete in one cycle; SB/SH run as a two-cycle
// read-modify-write (IDLE reads and merges, MERGE writes) stalling the core once.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   req_valid, req_write, funct3   core request qualifiers
//   addr, wdata                    byte address and store data
//   rdata                          extended load result (0 when no legal load)
//   stall                          hold the core for this cycle
//   misaligned                     current request is misaligned or illegal
//   err_sticky                     any misaligned/illegal request seen since reset
//   rmw_cnt                        completed SB/SH operations, saturating
//   mem_read, mem_write            data memory enables (never both set)
//   mem_addr, mem_wdata, mem_rdata data memory word interface
module lsu_rmw
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [2:0]        funct3,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              stall,
    output logic              misaligned,
    output logic              err_sticky,
    output logic [CNT_W-1:0]  rmw_cnt,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    state_t              state_q, state_d;
    logic [31:0]         buf_data_q, buf_data_d;
    logic [ADDR_W-1:0]   buf_addr_q, buf_addr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;

    logic [1:0]          offset;
    logic [ADDR_W-1:0]   word_addr;
    logic                req_idle;
    logic                bad_req;
    logic                is_load;
    logic                is_sw;
    logic                is_rmw;
    logic [31:0]         load_data;
    logic [31:0]         merge_data;

    // Bytes above the memory size wrap; the upper address bits are not used.
    logic                unused_addr_hi;
    assign unused_addr_hi = ^addr[31:ADDR_W+2];

    assign offset    = addr[1:0];
    assign word_addr = addr[ADDR_W+1:2];

    // Request inputs only matter in IDLE; in MERGE they are don't-care.
    always_comb begin
        req_idle = req_valid && (state_q == ST_IDLE);
        bad_req  = req_idle && access_bad(req_write, funct3, offset);
        is_load  = req_idle && !bad_req && !req_write;
        is_sw    = req_idle && !bad_req && req_write && (funct3 == F3_W);
        is_rmw   = req_idle && !bad_req && req_write && (funct3 != F3_W);
    end

    lsu_align u_align (
        .funct3     (funct3),
        .offset     (offset),
        .mem_rdata  (mem_rdata),
        .store_data (wdata[15:0]),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            buf_data_q <= '0;
            buf_addr_q <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_data_q <= buf_data_d;
            buf_addr_q <= buf_addr_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (is_rmw) state_d = ST_MERGE;
            ST_MERGE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rdata      = 32'h0000_0000;
        stall      = 1'b0;
        misaligned = bad_req;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = word_addr;
        mem_wdata  = wdata;
        case (state_q)
            ST_IDLE: begin
                if (is_load) begin
                    mem_read = 1'b1;
                    rdata    = load_data;
                end
                if (is_sw) begin
                    mem_write = 1'b1;
                end
                if (is_rmw) begin
                    mem_read = 1'b1;
                    stall    = 1'b1;
                end
            end
            ST_MERGE: begin
                mem_write = 1'b1;
                mem_addr  = buf_addr_q;
                mem_wdata = buf_data_q;
            end
            default: ;
        endcase
    end

    // Merge buffer captures the read half of the RMW; the counter advances as
    // each write half completes.
    always_comb begin
        buf_data_d = buf_data_q;
        buf_addr_d = buf_addr_q;
        cnt_d      = cnt_q;
        err_d      = err_q | bad_req;
        if (is_rmw) begin
            buf_data_d = merge_data;
            buf_addr_d = word_addr;
        end
        if ((state_q == ST_MERGE) && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign rmw_cnt    = cnt_q;
    assign err_sticky = err_q;

endmodule

// File: tb/tb_lsu_rmw.sv
// Self-checking bench for lsu_rmw: directed scenarios followed by random
// requests, all compared against a byte-lane reference model of memory.
module tb_lsu_rmw;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        misaligned;
    logic        err_sticky;
    logic [15:0] rmw_cnt;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [64];
    logic        preload_en;
    logic [5:0]  preload_addr;
    logic [31:0] preload_data;

    logic [31:0] ref_mem [64];
    int          ref_cnt;
    logic        ref_err;

    int          errors;
    int          checks;

    lsu_rmw #(.ADDR_W(6), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .stall      (stall),
        .misaligned (misaligned),
        .err_sticky (err_sticky),
        .rmw_cnt    (rmw_cnt),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Data memory: combinational read, posedge write, plus a bench preload port
    always @(posedge clk) begin
        if (mem_write)       mem[mem_addr] <= mem_wdata;
        else if (preload_en) mem[preload_addr] <= preload_data;
    end
    assign mem_rdata = mem[mem_addr];

    // Size in bytes of a funct3 code, 0 for codes that are never legal
    function automatic int ref_size(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic logic ref_legal(input logic wr, input logic [2:0] f3, input logic [31:0] a);
        int sz;
        sz = ref_size(f3);
        if (sz == 0) return 1'b0;
        if (wr && f3[2]) return 1'b0;
        return (a % sz) == 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [2:0] f3, input int off);
        logic [31:0]        sh;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        sh = word >> (8 * off);
        b  = sh[7:0];
        h  = sh[15:0];
        case (f3)
            3'b000:  return 32'($signed(b));
            3'b100:  return sh & 32'h0000_00FF;
            3'b001:  return 32'($signed(h));
            3'b101:  return sh & 32'h0000_FFFF;
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [2:0] f3, input int off, input logic [31:0] wd);
        logic [31:0] mask;
        mask = (f3 == 3'b000) ? 32'h0000_00FF : 32'h0000_FFFF;
        mask = mask << (8 * off);
        return (old & ~mask) | ((wd << (8 * off)) & mask);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic preload(input int w, input logic [31:0] d);
        @(negedge clk);
        preload_en   = 1'b1;
        preload_addr = 6'(w);
        preload_data = d;
        @(posedge clk);
        #1;
        preload_en   = 1'b0;
        ref_mem[w]   = d;
    endtask

    // One complete core request, including the MERGE cycle for SB/SH
    task automatic applyStimulus(input logic v, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 output logic [31:0] rdata_seen);
        int          w;
        int          off;
        logic        legal;
        logic        exp_load, exp_sw, exp_rmw;
        logic [31:0] exp_rdata;
        logic [31:0] exp_merge;
        w   = int'(a % 256) / 4;
        off = int'(a % 4);
        legal    = ref_legal(wr, f3, a);
        exp_load = v && legal && !wr;
        exp_sw   = v && legal && wr && (f3 == 3'b010);
        exp_rmw  = v && legal && wr && (f3 != 3'b010);
        exp_rdata = exp_load ? ref_load(ref_mem[w], f3, off) : 32'h0;

        @(negedge clk);
        req_valid = v;
        req_write = wr;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        #1;
        checkOutput("misaligned", {31'h0, misaligned}, {31'h0, v && !legal});
        checkOutput("stall", {31'h0, stall}, {31'h0, exp_rmw});
        checkOutput("mem_read", {31'h0, mem_read}, {31'h0, exp_load || exp_rmw});
        checkOutput("mem_write", {31'h0, mem_write}, {31'h0, exp_sw});
        checkOutput("rdata", rdata, exp_rdata);
        if (exp_load || exp_sw || exp_rmw)
            checkOutput("mem_addr", {26'h0, mem_addr}, 32'(w));
        if (exp_sw)
            checkOutput("mem_wdata_sw", mem_wdata, wd);
        rdata_seen = rdata;

        @(posedge clk);
        #1;
        if (v && !legal) ref_err = 1'b1;
        if (exp_sw) ref_mem[w] = wd;
        if (exp_rmw) begin
            exp_merge = ref_store(ref_mem[w], f3, off, wd);
            req_valid = 1'($urandom);
            req_write = 1'($urandom);
            funct3    = 3'($urandom);
            addr      = $urandom;
            wdata     = $urandom;
            #1;
            checkOutput("merge_stall", {31'h0, stall}, 32'h0);
            checkOutput("merge_write", {31'h0, mem_write}, 32'h1);
            checkOutput("merge_read", {31'h0, mem_read}, 32'h0);
            checkOutput("merge_addr", {26'h0, mem_addr}, 32'(w));
            checkOutput("merge_wdata", mem_wdata, exp_merge);
            checkOutput("merge_rdata", rdata, 32'h0);
            @(posedge clk);
            #1;
            ref_mem[w] = exp_merge;
            if (ref_cnt < 65535) ref_cnt++;
        end
        req_valid = 1'b0;
        checkOutput("err_sticky", {31'h0, err_sticky}, {31'h0, ref_err});
        checkOutput("rmw_cnt", {16'h0, rmw_cnt}, 32'(ref_cnt));
        checkOutput("mem_word", mem[w], ref_mem[w]);
    endtask

    initial begin
        logic [31:0] rd;
        logic [2:0]  f3r;
        logic [31:0] ar;
        logic [2:0]  legal_codes [5];
        errors = 0;
        checks = 0;
        ref_cnt = 0;
        ref_err = 1'b0;
        legal_codes[0] = 3'b000;
        legal_codes[1] = 3'b001;
        legal_codes[2] = 3'b010;
        legal_codes[3] = 3'b100;
        legal_codes[4] = 3'b101;
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        funct3 = 3'b000;
        addr = 32'h0;
        wdata = 32'h0;
        preload_en = 1'b0;
        preload_addr = 6'h0;
        preload_data = 32'h0;

        for (int i = 0; i < 64; i++) preload(i, $urandom);
        #1;
        checkOutput("reset_stall", {31'h0, stall}, 32'h0);
        checkOutput("reset_mem_write", {31'h0, mem_write}, 32'h0);
        checkOutput("reset_mem_read", {31'h0, mem_read}, 32'h0);
        checkOutput("reset_err", {31'h0, err_sticky}, 32'h0);
        checkOutput("reset_cnt", {16'h0, rmw_cnt}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // SB into word 1
        preload(1, 32'h0000_0009);
        applyStimulus(1'b1, 1'b1, 3'b000, 32'h05, 32'h0000_00AB, rd);
        checkOutput("sb_mem1", mem[1], 32'h0000_AB09);
        checkOutput("sb_cnt", {16'h0, rmw_cnt}, 32'h1);

        // Sign/zero extended loads from word 2
        preload(2, 32'h0000_80FF);
        applyStimulus(1'b1, 1'b0, 3'b000, 32'h08, 32'h0, rd);
        checkOutput("lb_lit", rd, 32'hFFFF_FFFF);
        applyStimulus(1'b1, 1'b0, 3'b100, 32'h08, 32'h0, rd);
        checkOutput("lbu_lit", rd, 32'h0000_00FF);
        applyStimulus(1'b1, 1'b0, 3'b001, 32'h08, 32'h0, rd);
        checkOutput("lh_lit", rd, 32'hFFFF_80FF);

        // Misaligned SH flags the error and leaves memory alone
        applyStimulus(1'b1, 1'b1, 3'b001, 32'h03, 32'h0000_1234, rd);
        checkOutput("sh_mis_err", {31'h0, err_sticky}, 32'h1);

        // Address wrap onto word 1
        preload(1, 32'h0000_0009);
        applyStimulus(1'b1, 1'b1, 3'b001, 32'h106, 32'h0000_BEEF, rd);
        checkOutput("sh_wrap_mem1", mem[1], 32'hBEEF_0009);

        // Reset during MERGE drops the write
        preload(3, 32'h1234_5678);
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        funct3    = 3'b000;
        addr      = 32'h0C;
        wdata     = 32'h0000_00EE;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checkOutput("rst_merge_write", {31'h0, mem_write}, 32'h1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_write_dropped", {31'h0, mem_write}, 32'h0);
        checkOutput("rst_stall", {31'h0, stall}, 32'h0);
        checkOutput("rst_cnt", {16'h0, rmw_cnt}, 32'h0);
        checkOutput("rst_err", {31'h0, err_sticky}, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("rst_mem3", mem[3], 32'h1234_5678);
        ref_cnt = 0;
        ref_err = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back SW then LW
        applyStimulus(1'b1, 1'b1, 3'b010, 32'h00, 32'h0000_0011, rd);
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h00, 32'h0, rd);
        checkOutput("sw_lw_lit", rd, 32'h0000_0011);

        // Random requests
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) == 0) f3r = 3'($urandom);
            else f3r = legal_codes[$urandom_range(0, 4)];
            ar = $urandom;
            if ($urandom_range(0, 1) == 1) ar = ar & 32'hFFFF_FFFC;
            applyStimulus($urandom_range(0, 7) != 0, 1'($urandom), f3r, ar, $urandom, rd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
